// File: rtl/sign_restore.sv
// Magnitude + sign to 17-bit two's-complement converter with a one-entry output
// register and a one-entry skid buffer. Optional neg_count under SIGN_RESTORE_STATS_EN.
module sign_restore (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_mag,
    input  logic        in_neg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_data,
    output logic        neg_zero,
`ifdef SIGN_RESTORE_STATS_EN
    output logic [15:0] neg_count,
`endif
    input  logic        clr_flag
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds its payload stable until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [16:0] conv;
    logic [16:0] skid_q;
    logic        accept;
    logic        deliver;
    logic        load_out;
    logic        load_skid;
    logic        move_skid;

    // ~{0,mag}+1 over 17 bits also yields 0 for a negative zero.
    assign conv    = in_neg ? (~{1'b0, in_mag} + 17'd1) : {1'b0, in_mag};
    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    // State register; in_ready and out_valid are registered copies of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_TWO);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !deliver)      state_nxt = ST_TWO;
                else if (!accept && deliver) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (deliver) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            ST_EMPTY: load_out = accept;
            ST_ONE: begin
                load_out  = accept && deliver;
                load_skid = accept && !deliver;
            end
            ST_TWO:   move_skid = deliver;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= 17'd0;
            skid_q   <= 17'd0;
        end else begin
            if (load_out)       out_data <= conv;
            else if (move_skid) out_data <= skid_q;
            if (load_skid)      skid_q   <= conv;
        end
    end

    // Setting wins over clearing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     neg_zero <= 1'b0;
        else if (accept && in_neg && in_mag == 16'd0) neg_zero <= 1'b1;
        else if (clr_flag)                           neg_zero <= 1'b0;
    end

`ifdef SIGN_RESTORE_STATS_EN
    // A negative deliver coinciding with clr_flag restarts the count at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_count <= 16'd0;
        end else if (clr_flag) begin
            neg_count <= (deliver && out_data[16]) ? 16'd1 : 16'd0;
        end else if (deliver && out_data[16]) begin
            neg_count <= neg_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sign_restore.sv
// Directed bench for sign_restore: integer reference model with an expected queue,
// a negedge compare process, and literal expectations on hand-computed vectors.
module tb_sign_restore;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mag;
    logic        in_neg;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic        neg_zero;
    logic        clr_flag;
`ifdef SIGN_RESTORE_STATS_EN
    logic [15:0] neg_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];
    logic        m_nz;
    logic [15:0] m_cnt;

    sign_restore dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .neg_zero  (neg_zero),
`ifdef SIGN_RESTORE_STATS_EN
        .neg_count (neg_count),
`endif
        .clr_flag  (clr_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_conv(input logic [15:0] m, input logic n);
        int v;
        v = n ? -int'(m) : int'(m);
        return v[16:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: the model holds every accepted-but-undelivered result.
    always @(negedge clk) begin
        logic        acc;
        logic        dlv;
        logic [16:0] e;
        if (rst) begin
            exp_q.delete();
            m_nz  = 1'b0;
            m_cnt = 16'd0;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_out_data", out_data, 0);
        end else begin
            check("occ_out_valid", out_valid, exp_q.size() > 0);
            check("occ_in_ready", in_ready, exp_q.size() < 2);
            check("neg_zero", neg_zero, m_nz);
`ifdef SIGN_RESTORE_STATS_EN
            check("neg_count", neg_count, m_cnt);
`endif
            acc = in_valid && (exp_q.size() < 2);
            dlv = out_ready && (exp_q.size() > 0);
            e   = 17'd0;
            if (dlv) begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
            end
            if (dlv && e[16]) m_cnt = clr_flag ? 16'd1 : m_cnt + 16'd1;
            else if (clr_flag) m_cnt = 16'd0;
            if (acc && in_neg && in_mag == 16'd0) m_nz = 1'b1;
            else if (clr_flag) m_nz = 1'b0;
            if (acc) exp_q.push_back(ref_conv(in_mag, in_neg));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] m, input logic n);
        logic acc;
        int   tries;
        in_valid = 1'b1;
        in_mag   = m;
        in_neg   = n;
        tries    = 0;
        do begin
            acc = in_ready;
            tick();
            tries++;
        end while (!acc && tries < 200);
        if (!acc) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int tries;
        tries = 0;
        while (out_valid && tries < 200) begin
            tick();
            tries++;
        end
        check("drain_done", out_valid, 0);
    endtask

    task automatic clr_pulse();
        clr_flag = 1'b1;
        tick();
        clr_flag = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mag    = 16'd0;
        in_neg    = 1'b0;
        out_ready = 1'b1;
        clr_flag  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_data", out_data, 0);
        check("reset_neg_zero", neg_zero, 0);
`ifdef SIGN_RESTORE_STATS_EN
        check("reset_neg_count", neg_count, 0);
`endif
        rst = 1'b0;
        tick();

        push(16'h0005, 1'b1);
        check("lit_neg5_valid", out_valid, 1);
        check("lit_neg5", out_data, 17'h1FFFB);
        push(16'hFFFF, 1'b0);
        check("lit_pos_ffff", out_data, 17'h0FFFF);
        push(16'hFFFF, 1'b1);
        check("lit_neg_ffff", out_data, 17'h10001);
        push(16'h0000, 1'b1);
        check("lit_negzero_data", out_data, 17'h00000);
        check("lit_negzero_flag", neg_zero, 1);
        tick();
        clr_pulse();
        check("lit_clr_flag", neg_zero, 0);
        clr_flag = 1'b1;
        push(16'h0000, 1'b1);
        clr_flag = 1'b0;
        check("lit_set_beats_clr", neg_zero, 1);
        clr_pulse();
        drain();

        // Backpressure: samples 1 and 2 fill both entries, 3 waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_neg    = 1'b0;
        in_mag    = 16'd1;
        tick();
        in_mag = 16'd2;
        tick();
        check("bp_ready_low", in_ready, 0);
        check("bp_hold1", out_data, 17'd1);
        in_mag = 16'd3;
        tick();
        check("bp_ready_still_low", in_ready, 0);
        check("bp_hold1_again", out_data, 17'd1);
        check("bp_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("bp_out2", out_data, 17'd2);
        check("bp_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_out3", out_data, 17'd3);
        check("bp_out3_valid", out_valid, 1);
        tick();
        check("bp_empty", out_valid, 0);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_mag   = 16'($urandom_range(0, 65535));
            in_neg   = 1'($urandom_range(0, 1));
            check("stream_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Reset while both entries are full.
        out_ready = 1'b0;
        push(16'd7, 1'b0);
        push(16'd8, 1'b1);
        check("two_ready_low", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_data", out_data, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_stale", out_valid, 0);
        end
        push(16'd9, 1'b0);
        check("post_rst_data", out_data, 17'd9);
        drain();

`ifdef SIGN_RESTORE_STATS_EN
        clr_pulse();
        push(16'd1, 1'b1);
        push(16'd2, 1'b0);
        push(16'd3, 1'b1);
        push(16'd4, 1'b0);
        push(16'd5, 1'b1);
        drain();
        check("lit_count3", neg_count, 16'd3);

        push(16'd3, 1'b1);
        clr_flag = 1'b1;
        tick();
        clr_flag = 1'b0;
        check("lit_inc_beats_clr", neg_count, 16'd1);

        clr_pulse();
        in_valid = 1'b1;
        in_neg   = 1'b1;
        in_mag   = 16'd1;
        for (int i = 0; i < 65535; i++) tick();
        in_valid = 1'b0;
        drain();
        check("lit_count_ffff", neg_count, 16'hFFFF);
        push(16'd1, 1'b1);
        drain();
        check("lit_count_wrap", neg_count, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_restore.md
# sign_restore

Converts a 16-bit unsigned magnitude plus a sign flag back into a 17-bit two's-complement sample; it is the inverse of the block that strips sign from 17-bit samples. It sits on the return path from the magnitude datapath toward the AHB-Lite slave result registers. A valid/ready handshake on both sides, a one-entry output register and a one-entry skid buffer give full throughput with a registered `in_ready`.

## Interface
- No parameters; widths are fixed at 16-bit magnitude and 17-bit result.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_mag`/`in_neg` hold a sample.
- `in_ready` out 1: block can accept a sample this cycle; registered.
- `in_mag` in 16: unsigned magnitude.
- `in_neg` in 1: 1 means the result is negative.
- `out_valid` out 1: `out_data` holds a result.
- `out_ready` in 1: downstream accepts the result this cycle.
- `out_data` out 17: two's-complement result.
- `neg_zero` out 1: sticky flag, set when a sample with `in_neg=1` and `in_mag=0` is accepted.
- `clr_flag` in 1: synchronous clear of `neg_zero`.
- `neg_count` out 16: number of negative results delivered. Present only with `SIGN_RESTORE_STATS_EN`.

## Operation
- Accept occurs when `in_valid && in_ready`. Deliver occurs when `out_valid && out_ready`.
- Conversion:
  - `in_neg=0`: `out_data = {1'b0, in_mag}`.
  - `in_neg=1`, `in_mag!=0`: `out_data = ~{1'b0, in_mag} + 1`, computed over 17 bits. The range reaches down to -65535 (0x10001), so no overflow is possible.
  - `in_neg=1`, `in_mag=0`: `out_data = 0`, and `neg_zero` is set at the same edge.
- The conversion is computed combinationally at the input; only the converted 17-bit value is stored.
- Occupancy state machine:
  - EMPTY: `out_valid=0`, `in_ready=1`. Accept → ONE.
  - ONE: the output register is full; `out_valid=1`, `in_ready=1`.
    - Accept and deliver in the same cycle: the new result loads the output register, stay in ONE.
    - Accept only: the new result goes to the skid buffer → TWO.
    - Deliver only → EMPTY.
  - TWO: both entries full; `out_valid=1`, `in_ready=0`.
    - Deliver: the skid entry moves to the output register → ONE.
    - Input is ignored while `in_ready=0`, even if `in_valid=1`.
- Ordering is strict FIFO; no result is dropped or duplicated.
- `neg_zero` priority: set wins over `clr_flag` when both occur in the same cycle.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `out_data=0`, `neg_zero=0`, `neg_count=0`. State is EMPTY and the skid buffer is cleared.
- Latency: a sample accepted at edge N appears on `out_data` with `out_valid=1` after edge N.
- Throughput: one sample per cycle while `out_ready=1`.
- `in_ready` falls in the cycle after the accept that fills the skid buffer. It rises in the cycle after the deliver that empties it.
- `out_data` and `out_valid` are held stable while `out_valid=1 && out_ready=0`.
- Reset asserted mid-stream discards both entries immediately, with no partial delivery.

## Configuration
- Macro: `SIGN_RESTORE_STATS_EN`.
- Defined:
  - The `neg_count` port exists.
  - It increments by 1 on each deliver whose `out_data[16]=1`.
  - It wraps from 0xFFFF to 0x0000.
  - It is cleared by `rst` and by `clr_flag`; an increment wins over `clr_flag` in the same cycle, leaving a count of 1.
- Undefined: the `neg_count` port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset, then single samples with `out_ready=1`:
  - `in_mag=0x0005`, `in_neg=1` → `out_data=0x1FFFB` one cycle later.
  - `in_mag=0xFFFF`, `in_neg=0` → `out_data=0x0FFFF`.
  - `in_mag=0xFFFF`, `in_neg=1` → `out_data=0x10001`.
- Negative zero: `in_mag=0`, `in_neg=1` → `out_data=0x00000` and `neg_zero=1`.
  - `clr_flag` pulse → `neg_zero=0`.
  - `clr_flag` in the same cycle as another negative-zero accept → `neg_zero` stays 1.
- Backpressure:
  - Hold `out_ready=0` and offer samples 1, 2, 3 back-to-back → samples 1 and 2 are accepted, and `in_ready=0` from the cycle after the second accept.
  - Release `out_ready` → outputs 1, 2, 3 in order with no gaps once sample 3 is accepted.
- Streaming: 100 random samples with `in_valid` and `out_ready` both held at 1 → one result per cycle, all matching the reference model, `in_ready` never low.
- Reset mid-operation: assert `rst` in state TWO → `out_valid=0` and `in_ready=1` immediately; no stale data appears after release.
- With `SIGN_RESTORE_STATS_EN`:
  - 3 negative and 2 positive delivers → `neg_count=3`.
  - Preload the counter to 0xFFFF by driving 65535 negative samples, then deliver one more → `neg_count=0x0000`.
